// File: rtl/writeback_regfile.sv
//------------------------------------------------------------------------------
// Module   : writeback_regfile
// Brief    : MEM/WB write-back select plus 32x32 MIPS register file with
//            same-cycle write-through bypass on the two ID read ports.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module writeback_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WB_in,
    input  logic              MemtoReg_in,
    input  logic [DATA_W-1:0] Read_data_in,
    input  logic [DATA_W-1:0] ALUresult_in,
    input  logic [ADDR_W-1:0] write_register_in,
    input  logic [ADDR_W-1:0] read_register1,
    input  logic [ADDR_W-1:0] read_register2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    input  logic [ADDR_W-1:0] dbg_register,
    output logic [DATA_W-1:0] dbg_data,
    output logic [31:0]       writeback_count
);

    localparam int          c_NREGS = 2 ** ADDR_W;
    localparam [ADDR_W-1:0] c_ZERO  = '0;

    // Declaration initialisers give the zeroed power-up state before any reset.
    logic [DATA_W-1:0] r_regs [c_NREGS] = '{default: '0};
    logic [31:0]       r_wb_count       = '0;

    logic [DATA_W-1:0] w_wdata;
    logic              w_commit;

    assign w_wdata  = MemtoReg_in ? Read_data_in : ALUresult_in;
    assign w_commit = WB_in && (write_register_in != c_ZERO) && !rst;

    // Entry 0 is never written because w_commit excludes index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wb_count <= '0;
        end else if (w_commit) begin
            r_regs[write_register_in] <= w_wdata;
            r_wb_count                <= r_wb_count + 32'd1;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] idx,
        input logic              in_rst,
        input logic              commit,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] val;
        val = stored;
        if (in_rst || idx == c_ZERO) begin
            val = '0;
        end else if (commit && idx == waddr) begin
            val = wdata;
        end
        return val;
    endfunction

    always_comb begin
        read_data1 = read_port(read_register1, rst, w_commit, write_register_in,
                               w_wdata, r_regs[read_register1]);
        read_data2 = read_port(read_register2, rst, w_commit, write_register_in,
                               w_wdata, r_regs[read_register2]);
    end

    // Debug port shows the raw array, so it lags a same-cycle commit by one edge.
    always_comb begin
        dbg_data = '0;
        if (dbg_register != c_ZERO) begin
            dbg_data = r_regs[dbg_register];
        end
    end

    assign writeback_count = r_wb_count;

endmodule

`default_nettype wire

// File: tb/tb_writeback_regfile.sv
//------------------------------------------------------------------------------
// Module   : tb_writeback_regfile
// Brief    : Directed self-checking bench for writeback_regfile.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_in;
    logic        MemtoReg_in;
    logic [31:0] Read_data_in;
    logic [31:0] ALUresult_in;
    logic [4:0]  write_register_in;
    logic [4:0]  read_register1;
    logic [4:0]  read_register2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [4:0]  dbg_register;
    logic [31:0] dbg_data;
    logic [31:0] writeback_count;

    int n_cmp = 0;
    int n_err = 0;

    writeback_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk               (clk),
        .rst               (rst),
        .WB_in             (WB_in),
        .MemtoReg_in       (MemtoReg_in),
        .Read_data_in      (Read_data_in),
        .ALUresult_in      (ALUresult_in),
        .write_register_in (write_register_in),
        .read_register1    (read_register1),
        .read_register2    (read_register2),
        .read_data1        (read_data1),
        .read_data2        (read_data2),
        .dbg_register      (dbg_register),
        .dbg_data          (dbg_data),
        .writeback_count   (writeback_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, then let inputs/outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input logic wb, input logic m2r, input logic [31:0] rd,
                            input logic [31:0] alu, input logic [4:0] wa);
        WB_in             = wb;
        MemtoReg_in       = m2r;
        Read_data_in      = rd;
        ALUresult_in      = alu;
        write_register_in = wa;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        read_register1 = '0;
        read_register2 = '0;
        dbg_register   = '0;
        drive_wr(1'b0, 1'b0, '0, '0, '0);
        tick();
        rst = 1'b0;

        // Preload r5 then reset with a concurrent write to r7
        drive_wr(1'b1, 1'b0, 32'h0, 32'h0000_1234, 5'd5);
        tick();
        dbg_register = 5'd5; #1;
        check("preload_r5", dbg_data, 32'h0000_1234);
        check("preload_cnt", writeback_count, 32'd1);

        rst = 1'b1;
        read_register1 = 5'd5;
        read_register2 = 5'd7;
        drive_wr(1'b1, 1'b0, 32'h0, 32'h0000_0077, 5'd7);
        check("rst_rd1_zero", read_data1, 32'h0);
        check("rst_rd2_nobypass", read_data2, 32'h0);
        tick();
        rst = 1'b0;
        drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        dbg_register = 5'd5; #1;
        check("rst_r5", dbg_data, 32'h0);
        dbg_register = 5'd7; #1;
        check("rst_r7", dbg_data, 32'h0);
        check("rst_cnt", writeback_count, 32'd0);

        // ALU-sourced then memory-sourced write to r8
        drive_wr(1'b1, 1'b0, 32'h1111_1111, 32'hDEAD_BEEF, 5'd8);
        tick();
        dbg_register = 5'd8; #1;
        check("alu_r8", dbg_data, 32'hDEAD_BEEF);
        check("alu_cnt", writeback_count, 32'd1);

        read_register1 = 5'd8;
        drive_wr(1'b1, 1'b1, 32'h0000_CAFE, 32'h2222_2222, 5'd8);
        check("mem_bypass_rd1", read_data1, 32'h0000_CAFE);
        check("mem_pre_dbg", dbg_data, 32'hDEAD_BEEF);
        tick();
        check("mem_r8", dbg_data, 32'h0000_CAFE);
        check("mem_cnt", writeback_count, 32'd2);

        // Dual-port bypass on r9
        drive_wr(1'b1, 1'b0, 32'h0, 32'h0000_0011, 5'd9);
        tick();
        read_register1 = 5'd9;
        read_register2 = 5'd9;
        dbg_register   = 5'd9;
        drive_wr(1'b1, 1'b0, 32'h0, 32'h0000_0022, 5'd9);
        check("byp_rd1", read_data1, 32'h0000_0022);
        check("byp_rd2", read_data2, 32'h0000_0022);
        check("byp_dbg_old", dbg_data, 32'h0000_0011);
        tick();
        check("byp_dbg_new", dbg_data, 32'h0000_0022);
        check("byp_cnt", writeback_count, 32'd4);

        // Write to r0 is dropped
        read_register1 = 5'd0;
        dbg_register   = 5'd0;
        drive_wr(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        check("r0_rd1_pre", read_data1, 32'h0);
        tick();
        check("r0_rd1_post", read_data1, 32'h0);
        check("r0_dbg", dbg_data, 32'h0);
        check("r0_cnt", writeback_count, 32'd4);

        // WB_in low: no commit, no bypass
        read_register1 = 5'd10;
        dbg_register   = 5'd10;
        drive_wr(1'b0, 1'b0, 32'h0, 32'h0000_0055, 5'd10);
        check("nowb_rd1", read_data1, 32'h0);
        tick();
        check("nowb_r10", dbg_data, 32'h0);
        check("nowb_cnt", writeback_count, 32'd4);

        // Ports are independent: rd1 bypasses r8, rd2 reads stored r9
        read_register1 = 5'd8;
        read_register2 = 5'd9;
        drive_wr(1'b1, 1'b0, 32'hFFFF_0000, 32'h0000_A5A5, 5'd8);
        check("indep_rd1", read_data1, 32'h0000_A5A5);
        check("indep_rd2", read_data2, 32'h0000_0022);
        tick();
        check("indep_cnt", writeback_count, 32'd5);

        // Counter wrap
        drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        force dut.r_wb_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_wb_count;
        #1;
        check("wrap_pre", writeback_count, 32'hFFFF_FFFF);
        dbg_register = 5'd11;
        drive_wr(1'b1, 1'b0, 32'h0, 32'h0000_0001, 5'd11);
        tick();
        check("wrap_cnt", writeback_count, 32'd0);
        check("wrap_r11", dbg_data, 32'h0000_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
